// File: rtl/key_pkg.sv
// Shared constants and types for the memory-mapped pushbutton device.
package key_pkg;

    localparam int          DBITS           = 32;
    localparam logic [31:0] KDATA_ADDR      = 32'hF000_0010;
    localparam logic [31:0] KCTRL_ADDR      = 32'hF000_0110;
    localparam int          DEBOUNCE_CYCLES = 500000;
    localparam int          CNT_BITS        = 20;
    localparam int          NUM_KEYS        = 4;

    localparam int READY_BIT   = 0;
    localparam int OVERRUN_BIT = 2;
    localparam int IE_BIT      = 8;

    typedef logic [NUM_KEYS-1:0] key_vec_t;

    typedef struct packed {
        logic ie;
        logic overrun;
        logic ready;
    } kctrl_t;

endpackage

// File: rtl/key_debouncer.sv
// Synchronises the active-low KEY pins and debounces them with one shared counter;
// update pulses combinationally in the cycle before stable takes the new value.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = key_pkg::DEBOUNCE_CYCLES,
    parameter int CNT_BITS        = key_pkg::CNT_BITS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key,
    output logic [3:0] stable,
    output logic       update
);
    import key_pkg::*;

    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

    key_vec_t            sync1, sync, prev, stable_next;
    logic [CNT_BITS-1:0] counter, counter_next;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        counter_next = '0;
        stable_next  = stable;
        update       = 1'b0;
        if (sync == stable) begin
            counter_next = '0;
        end else if (sync != prev) begin
            counter_next = '0;
        end else if (counter == CNT_LAST) begin
            stable_next = sync;
            update      = 1'b1;
        end else begin
            counter_next = counter + CNT_BITS'(1);
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= '0;
            sync    <= '0;
            prev    <= '0;
            counter <= '0;
            stable  <= '0;
        end else begin
            sync1   <= ~key;
            sync    <= sync1;
            prev    <= sync;
            counter <= counter_next;
            stable  <= stable_next;
        end
    end

endmodule

// File: rtl/key_controller.sv
// Pushbutton bus device: KDATA holds debounced keys, KCTRL holds Ready/Overrun/IE,
// and intr requests service while an unread change is pending and interrupts are enabled.
module key_controller #(
    parameter int               DBITS           = key_pkg::DBITS,
    parameter logic [DBITS-1:0] KDATA_ADDR      = key_pkg::KDATA_ADDR,
    parameter logic [DBITS-1:0] KCTRL_ADDR      = key_pkg::KCTRL_ADDR,
    parameter int               DEBOUNCE_CYCLES = key_pkg::DEBOUNCE_CYCLES,
    parameter int               CNT_BITS        = key_pkg::CNT_BITS
) (
    input  logic             clk,
    input  logic             reset,
    inout  wire  [DBITS-1:0] dbus,
    input  logic [DBITS-1:0] address,
    input  logic             wrtEn,
    input  logic [3:0]       KEY,
    output logic             intr
);
    import key_pkg::*;

    key_vec_t         stable;
    logic             update;
    logic             kdata_rd, kctrl_rd, kctrl_wr;
    logic [DBITS-1:0] rdata;
    logic             unused_wdata;
    kctrl_t           ctrl_q, ctrl_d;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_BITS       (CNT_BITS)
    ) u_debouncer (
        .clk   (clk),
        .reset (reset),
        .key   (KEY),
        .stable(stable),
        .update(update)
    );

    assign kdata_rd = (address == KDATA_ADDR) && !wrtEn;
    assign kctrl_rd = (address == KCTRL_ADDR) && !wrtEn;
    assign kctrl_wr = (address == KCTRL_ADDR) && wrtEn;

    always_comb begin
        rdata = '0;
        if (kdata_rd) begin
            rdata[NUM_KEYS-1:0] = stable;
        end else if (kctrl_rd) begin
            rdata[READY_BIT]   = ctrl_q.ready;
            rdata[OVERRUN_BIT] = ctrl_q.overrun;
            rdata[IE_BIT]      = ctrl_q.ie;
        end
    end

    assign dbus = (kdata_rd || kctrl_rd) ? rdata : 'z;

    // Only the IE and Overrun bits of a KCTRL write carry meaning.
    assign unused_wdata = ^dbus;

    // An update arriving with a KDATA read leaves the new value unread, so Ready stays set.
    always_comb begin
        ctrl_d = ctrl_q;
        if (kctrl_wr) begin
            ctrl_d.ie = dbus[IE_BIT];
            if (!dbus[OVERRUN_BIT]) ctrl_d.overrun = 1'b0;
        end
        if (kdata_rd) ctrl_d.ready = 1'b0;
        if (update) begin
            ctrl_d.ready = 1'b1;
            if (ctrl_q.ready && !kdata_rd) ctrl_d.overrun = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ctrl_q <= '0;
        else       ctrl_q <= ctrl_d;
    end

    assign intr = ctrl_q.ready & ctrl_q.ie;

endmodule

// File: doc/key_controller.md
Name: key_controller

Overview:
Memory-mapped pushbutton device on the processor data bus, a peer of the HEX display device at the same bus level.
- Synchronises and debounces the four active-low KEY pins.
- Latches the debounced state into KDATA and tracks an unread-change Ready flag, an Overrun flag and an interrupt-enable bit in KCTRL.
- Drives an interrupt request to the processor.
- Software typically reads KDATA and writes the value to the HEX device.

Parameters:
DBITS, 32, data/address bus width
KDATA_ADDR, 32'hF000_0010, read-only key data register address
KCTRL_ADDR, 32'hF000_0110, control/status register address
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required (10 ms at 50 MHz)
CNT_BITS, 20, debounce counter width; must hold DEBOUNCE_CYCLES-1

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
dbus  inout  DBITS  shared data bus; driven only during reads of this device
address  input  DBITS  bus address
wrtEn  input  1  1 = write cycle, 0 = read cycle
KEY  input  4  raw pushbuttons, active-low, asynchronous
intr  output  1  interrupt request = Ready & IE

Behaviour:
Interface
- One clock, clk; reset is synchronous, active-high, named reset.

Reset values
- All state cleared: sync stages, stable, prev, counter, Ready, Overrun, IE.
- intr = 0; dbus = high-Z.

Input path
- Invert KEY, then pass through a 2-flop synchroniser giving sync[3:0] (1 = pressed).
- prev holds sync from the previous cycle.

Debounce (shared counter for all 4 bits)
- If sync == stable: counter <= 0.
- Else if sync != prev: counter <= 0 (restart on any bounce).
- Else if counter == DEBOUNCE_CYCLES-1: stable <= sync, counter <= 0, raise a one-cycle update event.
- Else: counter <= counter + 1.
- Latency: a clean pin change becomes visible in stable DEBOUNCE_CYCLES+3 edges after the pin changes.

Register map
- KDATA read: {zeros, stable[3:0]}.
- KCTRL read: bit0 Ready, bit2 Overrun, bit8 IE, all other bits 0.
- Read data is combinational: dbus driven while address matches and wrtEn = 0.
- Unmatched address, or any write: dbus = high-Z.

Side effects (applied at the clock edge)
- KDATA read: Ready <= 0, every cycle the read is held.
- Update event: Ready <= 1. If Ready was 1 and no KDATA read occurs that cycle, Overrun <= 1.
- Update event and KDATA read in the same cycle: Ready = 1, Overrun unchanged. The read returned the old value; the new one is unread.
- KCTRL write: IE <= dbus[8].
  - Writing 0 to bit2 clears Overrun; writing 1 leaves it unchanged.
  - Bit0 and all other bits are ignored.
- KCTRL write coinciding with an Overrun-setting event: set wins.
- KDATA writes are ignored.

Outputs and reset timing
- intr is registered-state combinational: Ready & IE; it deasserts the cycle after the clearing read.
- Reset mid-debounce discards the count. stable returns to 0 with no update event, even if keys are held.
- After reset, held keys are debounced afresh and produce an update event.

Decomposition:
- Shared package key_pkg:
  - Address constants KDATA_ADDR and KCTRL_ADDR.
  - KCTRL bit positions: READY_BIT = 0, OVERRUN_BIT = 2, IE_BIT = 8.
  - Default DEBOUNCE_CYCLES.
- One sub-module, key_debouncer:
  - Contains the synchroniser, prev, counter and stable.
  - Outputs stable[3:0] and the update pulse.
- Bus decode and the Ready/Overrun/IE register stay in key_controller.

Test Plan:
1. Reset, then KCTRL read and KDATA read (address F000_0110 / F000_0010, wrtEn = 0) -> dbus = 32'h0 for both; intr = 0; with no address match, dbus = Z.
2. DEBOUNCE_CYCLES = 4; KEY goes 4'b1111 -> 4'b1110 and holds -> KDATA reads 32'h1 exactly 7 edges later; KCTRL reads 32'h1; a subsequent KDATA read clears Ready (KCTRL = 32'h0).
3. KEY toggles bit0 every 2 cycles for 20 cycles, then settles at 4'b1111 -> stable never changes, Ready stays 0.
4. Press KEY[1] without reading, then release -> second update sets Overrun (KCTRL = 32'h5). KCTRL write 32'h0 -> KCTRL = 32'h1. KCTRL write 32'h4 -> Overrun stays 0.
5. KCTRL write 32'h100, then a key press -> intr rises on the same edge Ready sets; a KDATA read drops intr one edge later. An update coinciding with the read leaves Ready = 1 and Overrun = 0.
6. Assert reset while the counter = 2 with KEY held at 4'b0111 -> all registers 0. After release, KDATA = 32'h8 after DEBOUNCE_CYCLES+3 edges with Ready = 1.
